// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared state encoding and default timing for the bank sequencer
// Purpose: the bank FSM state enum, legacy-compatible state constants, and the
//          default TRCD/TRP/COLS values used by bank_sequencer.
// Ports:   none (package).
package bank_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACT_WAIT = 2'd1,
    OPEN     = 2'd2,
    PRE_WAIT = 2'd3
  } bank_state_e;

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_ACT_WAIT = ACT_WAIT;
  localparam logic [1:0] ST_OPEN     = OPEN;
  localparam logic [1:0] ST_PRE_WAIT = PRE_WAIT;

  localparam int DEF_TRCD = 2;
  localparam int DEF_TRP  = 2;
  localparam int DEF_COLS = 32;

endpackage

// File: rtl/bank_sequencer_if.sv
// rtl/bank_sequencer_if.sv - request/response handshake bundle of the bank sequencer
// Purpose: groups the upstream request handshake and the read response.
// Ports:   req_valid/req_ready/req_wr/req_addr/req_wdata (request),
//          rsp_valid/rsp_rdata (read response).
//          master = requester side, slave = bank_sequencer side.
interface bank_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 11
);
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/tim_counter.sv
// rtl/tim_counter.sv - loadable down-counter with zero flag
// Purpose: times the activate and precharge waits of the bank sequencer.
// Ports:   clk, reset (async, active-high), load/load_val (reload the count),
//          zero (count has reached 0; counting stops there).
module tim_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bank_sequencer.sv
// rtl/bank_sequencer.sv - single-bank open-row sequencer in front of a memory array
// Purpose: opens a row (ACT_WAIT), streams hits to the array one per cycle while
//          the row is open, and precharges (PRE_WAIT) on a row miss.
// Ports:   clk, reset (async, active-high); bus (slave side of bank_sequencer_if);
//          arr_addr/arr_rd_o_wr/arr_i_data/arr_o_data to the external array
//          (synchronous read: data for a read handshake arrives next cycle);
//          open_row_valid/open_row, hit_count/miss_count (saturating).
module bank_sequencer
  import bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048,
  parameter int COLS  = DEF_COLS,
  parameter int TRCD  = DEF_TRCD,
  parameter int TRP   = DEF_TRP,
  parameter int CNTW  = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CB   = $clog2(COLS),
  localparam int RB   = AW - CB
) (
  input  logic             clk,
  input  logic             reset,
  bank_sequencer_if.slave  bus,
  output logic [AW-1:0]    arr_addr,
  output logic             arr_rd_o_wr,
  output logic [WIDTH-1:0] arr_i_data,
  input  logic [WIDTH-1:0] arr_o_data,
  output logic             open_row_valid,
  output logic [RB-1:0]    open_row,
  output logic [CNTW-1:0]  hit_count,
  output logic [CNTW-1:0]  miss_count
);

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TW   = $clog2(TMAX + 1);

  logic [1:0]    state;
  logic [RB-1:0] req_row;
  logic          row_hit;
  logic          handshake;
  logic          tim_load;
  logic [TW-1:0] tim_val;
  logic          tim_zero;

  assign req_row   = bus.req_addr[AW-1:CB];
  assign row_hit   = (req_row == open_row);
  assign handshake = (state == ST_OPEN) && bus.req_valid && row_hit;

  assign bus.req_ready  = handshake;
  assign bus.rsp_rdata  = arr_o_data;
  assign arr_addr       = bus.req_addr;
  assign arr_i_data     = bus.req_wdata;
  assign arr_rd_o_wr    = handshake && bus.req_wr;
  assign open_row_valid = (state == ST_OPEN);

  // The wait state is entered the cycle after the load, so loading N-1 makes
  // the wait last exactly N cycles (leaves on the cycle the count reads zero).
  always_comb begin
    tim_load = 1'b0;
    tim_val  = '0;
    if (state == ST_IDLE && bus.req_valid) begin
      tim_load = 1'b1;
      tim_val  = TW'(TRCD - 1);
    end else if (state == ST_OPEN && bus.req_valid && !row_hit) begin
      tim_load = 1'b1;
      tim_val  = TW'(TRP - 1);
    end
  end

  tim_counter #(.W(TW)) u_tim (
    .clk      (clk),
    .reset    (reset),
    .load     (tim_load),
    .load_val (tim_val),
    .zero     (tim_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      open_row      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      bus.rsp_valid <= 1'b0;
    end else begin
      bus.rsp_valid <= handshake && !bus.req_wr;

      if (handshake && hit_count != '1) begin
        hit_count <= hit_count + CNTW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            open_row <= req_row;
            if (miss_count != '1) begin
              miss_count <= miss_count + CNTW'(1);
            end
            state <= ST_ACT_WAIT;
          end
        end
        ST_ACT_WAIT: begin
          if (tim_zero) state <= ST_OPEN;
        end
        ST_OPEN: begin
          if (bus.req_valid && !row_hit) state <= ST_PRE_WAIT;
        end
        ST_PRE_WAIT: begin
          if (tim_zero) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
